// File: rtl/cpstr_demux_rx.sv
// -----------------------------------------------------------------------------
// cpstr_demux_rx
//
// Receive-side stream demultiplexer. Consumes the escaped byte stream coming
// out of the link RX FIFO and routes data bytes to one of NUM_STREAMS
// valid/ready consumers.
//
// Stream encoding:
//   {ESC_CHAR, idx}       select stream idx (idx = 0 .. NUM_STREAMS-1)
//   {ESC_CHAR, ESC_CHAR}  literal ESC_CHAR data byte
//   any other byte        data byte for the currently selected stream
//
// A single output register {byte, dst} sits between the input and all the
// stream lanes. It accepts a new byte in the same cycle it drains, so a
// consumer that is always ready sees one byte per cycle. Each accepted data
// byte appears on o_valid one cycle after it is accepted.
//
// Ports:
//   i_clk         clock
//   i_rst_n       asynchronous reset, active low
//   i_data        escaped input byte
//   i_valid       input byte valid
//   o_ready       input byte accepted when i_valid && o_ready
//   o_data        one byte lane per stream; every lane carries the output register
//   o_valid       one-hot or zero; bit k = byte pending for stream k
//   i_ready       per-stream consumer ready
//   o_sel         currently selected stream index
//   o_sel_ok      a valid index has been selected (and not invalidated since)
//   o_err         one-cycle pulse on a protocol error
//
// Optional feature, macro CPSTR_DEMUX_ERRCNT_EN:
//   i_errcnt_clr  synchronous clear of the error counter (wins over a new error)
//   o_errcnt      saturating count of o_err pulses
// -----------------------------------------------------------------------------
module cpstr_demux_rx #(
  parameter int          NUM_STREAMS = 2,
  parameter logic [7:0]  ESC_CHAR    = 8'hFF,
  localparam int         SW          = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [8*NUM_STREAMS-1:0]   o_data,
  output logic [NUM_STREAMS-1:0]     o_valid,
  input  logic [NUM_STREAMS-1:0]     i_ready,
  output logic [SW-1:0]              o_sel,
  output logic                       o_sel_ok,
  output logic                       o_err
`ifdef CPSTR_DEMUX_ERRCNT_EN
  ,
  input  logic                       i_errcnt_clr,
  output logic [7:0]                 o_errcnt
`endif
);

  typedef enum logic {
    S_DATA = 1'b0,
    S_ESC  = 1'b1
  } state_t;

  state_t          state_q, state_d;

  // Output register.
  logic            full_q;
  logic [7:0]      byte_q;
  logic [SW-1:0]   dst_q;

  // Stream selection.
  logic [SW-1:0]   sel_q, sel_d;
  logic            sel_ok_q, sel_ok_d;

  logic            err_q, err_d;
  logic            load;
  logic            accept;
  logic            drain;
  logic            is_esc;
  logic            is_idx;

  // The register may take a new byte whenever it is empty or draining this
  // cycle. The byte value plays no part, so markers see the same handshake.
  assign drain   = full_q && i_ready[dst_q];
  assign o_ready = !full_q || i_ready[dst_q];
  assign accept  = i_valid && o_ready;

  // Index check on the whole byte: 0x02..0xFE must not alias onto a valid
  // index by truncation. ESC_CHAR is tested first so it is never an index.
  assign is_esc = (i_data == ESC_CHAR);
  assign is_idx = !is_esc && (32'(i_data) < NUM_STREAMS);

  // NOTE: every signal written here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sel_ok_d = sel_ok_q;
    err_d    = 1'b0;
    load     = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_DATA: begin
          if (is_esc) begin
            state_d = S_ESC;
          end else if (sel_ok_q) begin
            load = 1'b1;
          end else begin
            err_d = 1'b1;           // data with no stream selected: dropped
          end
        end

        S_ESC: begin
          state_d = S_DATA;
          if (is_esc) begin
            // Literal ESC_CHAR follows the ordinary data-byte rules.
            if (sel_ok_q) load  = 1'b1;
            else          err_d = 1'b1;
          end else if (is_idx) begin
            sel_d    = i_data[SW-1:0];
            sel_ok_d = 1'b1;
          end else begin
            // Bad index: drop everything until the next good marker.
            sel_ok_d = 1'b0;
            err_d    = 1'b1;
          end
        end

        default: state_d = S_DATA;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_DATA;
      sel_q    <= '0;
      sel_ok_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sel_ok_q <= sel_ok_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the output byte is reset as well, since o_data is visible and must
  // read zero after reset; a pure datapath register could skip the reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      byte_q <= '0;
      dst_q  <= '0;
    end else begin
      if (load) begin
        // dst is captured with the byte, so a later select cannot retarget
        // a byte that is still waiting for its consumer.
        full_q <= 1'b1;
        byte_q <= i_data;
        dst_q  <= sel_q;
      end else if (drain) begin
        full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    o_valid = '0;
    if (full_q) o_valid[dst_q] = 1'b1;
  end

  assign o_data   = {NUM_STREAMS{byte_q}};
  assign o_sel    = sel_q;
  assign o_sel_ok = sel_ok_q;
  assign o_err    = err_q;

`ifdef CPSTR_DEMUX_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Counts on the same edge that raises o_err.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      errcnt_q <= '0;
    end else if (i_errcnt_clr) begin
      errcnt_q <= '0;
    end else if (err_d && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign o_errcnt = errcnt_q;
`endif

endmodule
